// File: rtl/md5_crack_pkg.sv
// Shared constants and types for the MD5 cracker: guess alphabet bounds,
// plaintext bus width and the guess generator state encoding.
package md5_crack_pkg;
  localparam logic [7:0] CHAR_MIN      = 8'h61;  // 'a'
  localparam logic [7:0] CHAR_MAX      = 8'h7A;  // 'z'
  localparam int         ALPHABET_SIZE = 26;
  localparam int         PLAINTEXT_W   = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } gen_state_t;

  // Anything outside 'a'..'z' starts the odometer at 'a'.
  function automatic logic [7:0] clamp_char(input logic [7:0] c);
    return (c < CHAR_MIN || c > CHAR_MAX) ? CHAR_MIN : c;
  endfunction
endpackage

// File: rtl/char_stride_adder.sv
// One odometer digit: adds a 0..7 increment to a lowercase character and
// wraps back into 'a'..'z' with a carry.
//   char_in   current character (or 0 for an unused position)
//   add_in    stride (digit 0) or carry-in (higher digits)
//   char_out  advanced character
//   carry_out digit wrapped past 'z'
module char_stride_adder
  import md5_crack_pkg::*;
(
  input  logic [7:0] char_in,
  input  logic [2:0] add_in,
  output logic [7:0] char_out,
  output logic       carry_out
);
  logic [7:0] sum;

  // 'z' + 7 = 129 still fits in 8 bits, and 7 < 26 so one wrap suffices.
  assign sum       = char_in + {5'd0, add_in};
  assign carry_out = (sum > CHAR_MAX);
  assign char_out  = carry_out ? (sum - 8'(ALPHABET_SIZE)) : sum;
endmodule

// File: rtl/password_guess_generator.sv
// Plaintext guess source for the MD5 cracker. Walks lowercase strings as an
// odometer (start character + stride) so several cores can split the space,
// presenting each guess over valid/ready until found or keyspace exhaustion.
//   clk, reset       clock, async active-high reset
//   start            pulse: load first guess, enter RUN (any state)
//   start_char       first character, clamped to 'a'..'z'
//   increment        stride per guess, 0 behaves as 1
//   ready            MD5 path takes the current guess
//   found            comparator hit; stop in RUN
//   word_out         right-aligned guess, last char in [7:0], upper bytes 0
//   word_len         valid characters
//   valid            guess pending acceptance
//   exhausted        overflowed past MAX_LEN (sticky until start)
//   busy             state == RUN
//   count            accepted guesses since start, saturating
module password_guess_generator
  import md5_crack_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int COUNT_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [7:0]           start_char,
  input  logic [2:0]           increment,
  input  logic                 ready,
  input  logic                 found,
  output logic [8*MAX_LEN-1:0] word_out,
  output logic [4:0]           word_len,
  output logic                 valid,
  output logic                 exhausted,
  output logic                 busy,
  output logic [COUNT_W-1:0]   count
);
  gen_state_t                 state;
  logic [2:0]                 stride_q;
  logic [MAX_LEN-1:0][7:0]    word_q;
  logic [MAX_LEN-1:0][7:0]    word_adv;
  logic [MAX_LEN-1:0][7:0]    word_nxt;
  logic [MAX_LEN:1]           carry;     // carry[i+1] = carry out of digit i
  logic                       top_carry;
  logic                       grow;
  logic                       overflow;
  logic                       xfer;

  // Digits above word_len hold 0 and never carry, so the chain can run
  // across the full width unconditionally.
  for (genvar i = 0; i < MAX_LEN; i++) begin : g_lane
    logic [2:0] add;
    if (i == 0) begin : g_lsd
      assign add = stride_q;
    end else begin : g_hsd
      assign add = {2'b00, carry[i]};
    end
    char_stride_adder u_add (
      .char_in  (word_q[i]),
      .add_in   (add),
      .char_out (word_adv[i]),
      .carry_out(carry[i+1])
    );
  end

  always_comb begin
    top_carry = 1'b0;
    for (int i = 0; i < MAX_LEN; i++)
      if (5'(i + 1) == word_len) top_carry = carry[i+1];
  end

  assign grow     = top_carry && (word_len < 5'(MAX_LEN));
  assign overflow = carry[MAX_LEN];
  assign xfer     = valid && ready;

  // The digit just above the current length would see 0+carry = 1; replace
  // it with 'a' when the string grows, keep it 0 otherwise.
  always_comb begin
    word_nxt = word_adv;
    for (int i = 0; i < MAX_LEN; i++)
      if (5'(i) == word_len) word_nxt[i] = grow ? CHAR_MIN : 8'h00;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      stride_q  <= 3'd1;
      word_q    <= '0;
      word_len  <= '0;
      valid     <= 1'b0;
      exhausted <= 1'b0;
      busy      <= 1'b0;
      count     <= '0;
    end else if (start) begin
      state     <= RUN;
      stride_q  <= (increment == 3'd0) ? 3'd1 : increment;
      word_q    <= '0;
      word_q[0] <= clamp_char(start_char);
      word_len  <= 5'd1;
      valid     <= 1'b1;
      exhausted <= 1'b0;
      busy      <= 1'b1;
      count     <= '0;
    end else if (state == RUN) begin
      if (xfer && count != '1) count <= count + COUNT_W'(1);
      if (found) begin
        // A coincident transfer is counted above but the word is kept.
        state <= DONE;
        valid <= 1'b0;
        busy  <= 1'b0;
      end else if (xfer) begin
        if (overflow) begin
          state     <= DONE;
          valid     <= 1'b0;
          busy      <= 1'b0;
          exhausted <= 1'b1;
        end else begin
          word_q <= word_nxt;
          if (grow) word_len <= word_len + 5'd1;
        end
      end
    end
  end

  assign word_out = word_q;
endmodule

// File: tb/tb_password_guess_generator.sv
module tb_password_guess_generator;
  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [7:0]   start_char = 8'h61;
  logic [2:0]   increment = 3'd1;
  logic         ready = 1'b0;
  logic         found = 1'b0;

  logic [127:0] word_out;
  logic [4:0]   word_len;
  logic         valid, exhausted, busy;
  logic [31:0]  count;

  logic [15:0]  word_out_s;
  logic [4:0]   word_len_s;
  logic         valid_s, exhausted_s, busy_s;
  logic [31:0]  count_s;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  password_guess_generator dut (
    .clk(clk), .reset(reset), .start(start), .start_char(start_char),
    .increment(increment), .ready(ready), .found(found),
    .word_out(word_out), .word_len(word_len), .valid(valid),
    .exhausted(exhausted), .busy(busy), .count(count)
  );

  password_guess_generator #(.MAX_LEN(2), .COUNT_W(32)) dut_s (
    .clk(clk), .reset(reset), .start(start), .start_char(start_char),
    .increment(increment), .ready(ready), .found(found),
    .word_out(word_out_s), .word_len(word_len_s), .valid(valid_s),
    .exhausted(exhausted_s), .busy(busy_s), .count(count_s)
  );

  function automatic logic [127:0] w1(input logic [7:0] c);
    return {120'd0, c};
  endfunction

  function automatic logic [127:0] w2(input logic [7:0] hi, input logic [7:0] lo);
    return {112'd0, hi, lo};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] c, input logic [2:0] inc);
    start_char = c;
    increment  = inc;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #2;
    if (word_out !== 128'd0) begin $display("FAIL reset_word got %h exp 0", word_out); n_bad++; end
    n_cmp++;
    if ({word_len, valid, exhausted, busy} !== 8'd0) begin
      $display("FAIL reset_flags got len=%0d v=%b e=%b b=%b exp all 0", word_len, valid, exhausted, busy); n_bad++;
    end
    n_cmp++;
    if (count !== 32'd0) begin $display("FAIL reset_count got %0d exp 0", count); n_bad++; end
    n_cmp++;
    #3 reset = 1'b0;
    tick();
  endtask

  // 'a'..'z', "aa", "ab" with stride 1
  task automatic test_sequence();
    logic [127:0] exp;
    ready = 1'b1;
    do_start(8'h61, 3'd1);
    for (int k = 0; k < 28; k++) begin
      exp = (k < 26) ? w1(8'h61 + 8'(k)) : w2(8'h61, 8'h61 + 8'(k - 26));
      if (word_out !== exp || valid !== 1'b1) begin
        $display("FAIL seq_word[%0d] got %h v=%b exp %h v=1", k, word_out, valid, exp); n_bad++;
      end
      n_cmp++;
      if (count !== 32'(k)) begin $display("FAIL seq_count[%0d] got %0d exp %0d", k, count, k); n_bad++; end
      n_cmp++;
      if (word_len !== ((k < 26) ? 5'd1 : 5'd2)) begin
        $display("FAIL seq_len[%0d] got %0d exp %0d", k, word_len, (k < 26) ? 1 : 2); n_bad++;
      end
      n_cmp++;
      tick();
    end
    if (count !== 32'd28) begin $display("FAIL seq_final_count got %0d exp 28", count); n_bad++; end
    n_cmp++;
  endtask

  // Stride 3 from 'b': b e h k n q t w z ac af; from 'y': y ab ae
  task automatic test_stride();
    logic [7:0]   singles [9];
    logic [127:0] doubles [2];
    singles = '{8'h62, 8'h65, 8'h68, 8'h6b, 8'h6e, 8'h71, 8'h74, 8'h77, 8'h7a};
    doubles = '{w2(8'h61, 8'h63), w2(8'h61, 8'h66)};
    ready = 1'b1;
    do_start(8'h62, 3'd3);
    increment = 3'd7;  // must not affect the running stride
    for (int k = 0; k < 9; k++) begin
      if (word_out !== w1(singles[k])) begin
        $display("FAIL stride_b[%0d] got %h exp %h", k, word_out, w1(singles[k])); n_bad++;
      end
      n_cmp++;
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      if (word_out !== doubles[k]) begin
        $display("FAIL stride_b2[%0d] got %h exp %h", k, word_out, doubles[k]); n_bad++;
      end
      n_cmp++;
      tick();
    end
    do_start(8'h79, 3'd3);
    if (word_out !== w1(8'h79)) begin $display("FAIL stride_y0 got %h exp 79", word_out); n_bad++; end
    n_cmp++;
    tick();
    if (word_out !== w2(8'h61, 8'h62) || word_len !== 5'd2) begin
      $display("FAIL stride_y1 got %h len %0d exp 6162 len 2", word_out, word_len); n_bad++;
    end
    n_cmp++;
    tick();
    if (word_out !== w2(8'h61, 8'h65)) begin $display("FAIL stride_y2 got %h exp 6165", word_out); n_bad++; end
    n_cmp++;
  endtask

  task automatic test_clamp();
    ready = 1'b1;
    do_start(8'h41, 3'd0);
    if (word_out !== w1(8'h61)) begin $display("FAIL clamp_low got %h exp 61", word_out); n_bad++; end
    n_cmp++;
    tick();
    if (word_out !== w1(8'h62)) begin $display("FAIL zero_stride got %h exp 62", word_out); n_bad++; end
    n_cmp++;
    do_start(8'h7b, 3'd1);
    if (word_out !== w1(8'h61)) begin $display("FAIL clamp_high got %h exp 61", word_out); n_bad++; end
    n_cmp++;
  endtask

  task automatic test_backpressure();
    ready = 1'b1;
    do_start(8'h61, 3'd1);
    tick();
    tick();
    ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (word_out !== w1(8'h63) || valid !== 1'b1 || count !== 32'd2) begin
        $display("FAIL bp_hold[%0d] got %h v=%b cnt=%0d exp 63 v=1 cnt=2", k, word_out, valid, count); n_bad++;
      end
      n_cmp++;
    end
    ready = 1'b1;
    tick();
    if (word_out !== w1(8'h64) || count !== 32'd3) begin
      $display("FAIL bp_resume got %h cnt=%0d exp 64 cnt=3", word_out, count); n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_found();
    ready = 1'b1;
    do_start(8'h61, 3'd1);
    for (int k = 0; k < 16; k++) tick();
    if (word_out !== w1(8'h71)) begin $display("FAIL found_pre got %h exp 71", word_out); n_bad++; end
    n_cmp++;
    found = 1'b1;
    tick();
    found = 1'b0;
    if (valid !== 1'b0 || busy !== 1'b0 || exhausted !== 1'b0) begin
      $display("FAIL found_stop got v=%b b=%b e=%b exp 0 0 0", valid, busy, exhausted); n_bad++;
    end
    n_cmp++;
    if (word_out !== w1(8'h71) || count !== 32'd17) begin
      $display("FAIL found_hold got %h cnt=%0d exp 71 cnt=17", word_out, count); n_bad++;
    end
    n_cmp++;
    tick();
    if (word_out !== w1(8'h71) || valid !== 1'b0) begin
      $display("FAIL found_done_hold got %h v=%b exp 71 v=0", word_out, valid); n_bad++;
    end
    n_cmp++;
    do_start(8'h61, 3'd1);
    if (word_out !== w1(8'h61) || count !== 32'd0 || valid !== 1'b1 || busy !== 1'b1) begin
      $display("FAIL found_restart got %h cnt=%0d v=%b b=%b exp 61 0 1 1", word_out, count, valid, busy); n_bad++;
    end
    n_cmp++;
  endtask

  // MAX_LEN=2 instance: 26 + 676 = 702 guesses, last "zz"
  task automatic test_exhaust();
    ready = 1'b1;
    do_start(8'h61, 3'd1);
    for (int k = 0; k < 701; k++) tick();
    if (word_out_s !== 16'h7a7a || valid_s !== 1'b1 || word_len_s !== 5'd2) begin
      $display("FAIL exh_last got %h v=%b len=%0d exp 7a7a v=1 len=2", word_out_s, valid_s, word_len_s); n_bad++;
    end
    n_cmp++;
    tick();
    if (exhausted_s !== 1'b1 || valid_s !== 1'b0 || busy_s !== 1'b0) begin
      $display("FAIL exh_flags got e=%b v=%b b=%b exp 1 0 0", exhausted_s, valid_s, busy_s); n_bad++;
    end
    n_cmp++;
    if (count_s !== 32'd702 || word_out_s !== 16'h7a7a) begin
      $display("FAIL exh_count got cnt=%0d w=%h exp 702 7a7a", count_s, word_out_s); n_bad++;
    end
    n_cmp++;
    do_start(8'h61, 3'd1);
    if (exhausted_s !== 1'b0 || valid_s !== 1'b1) begin
      $display("FAIL exh_clear got e=%b v=%b exp 0 1", exhausted_s, valid_s); n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_async_reset();
    ready = 1'b1;
    do_start(8'h61, 3'd1);
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    if (word_out !== 128'd0 || word_len !== 5'd0 || count !== 32'd0) begin
      $display("FAIL areset_data got %h len=%0d cnt=%0d exp 0", word_out, word_len, count); n_bad++;
    end
    n_cmp++;
    if ({valid, exhausted, busy, valid_s, busy_s} !== 5'd0) begin
      $display("FAIL areset_flags got v=%b e=%b b=%b exp 0", valid, exhausted, busy); n_bad++;
    end
    n_cmp++;
    #1 reset = 1'b0;
    tick();
  endtask

  task automatic test_start_priority();
    ready = 1'b1;
    do_start(8'h63, 3'd1);
    tick();
    start_char = 8'h61;
    increment  = 3'd1;
    start = 1'b1;
    found = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    if (word_out !== w1(8'h61) || valid !== 1'b1 || busy !== 1'b1 || count !== 32'd0) begin
      $display("FAIL start_prio got %h v=%b b=%b cnt=%0d exp 61 1 1 0", word_out, valid, busy, count); n_bad++;
    end
    n_cmp++;
    tick();
    if (word_out !== w1(8'h62) || count !== 32'd1) begin
      $display("FAIL start_prio_next got %h cnt=%0d exp 62 1", word_out, count); n_bad++;
    end
    n_cmp++;
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_stride();
    test_clamp();
    test_backpressure();
    test_found();
    test_exhaust();
    test_async_reset();
    test_start_priority();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
